store_checker: RTL and testbench

- Synthesizable self-check monitor sitting directly downstream of the multicycle MIPS `top`.
- Snoops the processor's memory-write bus (memwrite, dataadr, writedata) and compares stores into a fixed result window against a parameterised table of expected words.
- Reports pass/fail/timeout status as registered outputs, so the same check runs on FPGA (LEDs) and in simulation, with no dependence on a behavioural bench.

---
 rtl/store_checker.sv | 146 ++++++++++++++
 tb/tb_store_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_checker.sv
// Self-check monitor for the multicycle MIPS core: snoops the store bus and
// compares stores into a fixed result window against a table of expected words.
// Reports IDLE/RUN/PASS/FAIL with sticky terminal states and a RUN-time timeout.
module store_checker #(
  parameter int unsigned          NCHK        = 4,
  parameter logic [31:0]          ADDR0       = 32'd200,
  parameter logic [NCHK*32-1:0]   EXP         = {32'h000000C8, 32'h00000064,
                                                 32'hffffffff, 32'h00000001},
  parameter int unsigned          TIMEOUT_CYC = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwrite,
  input  logic [31:0]     dataadr,
  input  logic [31:0]     writedata,
  output logic [1:0]      state,
  output logic            done,
  output logic            fail,
  output logic            timeout,
  output logic [NCHK-1:0] hit_mask,
  output logic [31:0]     err_addr,
  output logic [31:0]     err_data
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StPass = 2'b10,
    StFail = 2'b11
  } state_e;

  // Elaboration-time parameter sanity checks.
  if (NCHK == 0 || NCHK > 16) begin : g_bad_nchk
    $error("store_checker: NCHK must be in 1..16");
  end
  if ({32'd0, ADDR0} + 64'(4 * NCHK) > 64'h1_0000_0000) begin : g_bad_addr
    $error("store_checker: result window wraps past 2^32");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("store_checker: TIMEOUT_CYC must be >= 1");
  end

  // Exclusive upper bound of the window, one bit wider so it cannot wrap.
  localparam logic [32:0] WinEnd = {1'b0, ADDR0} + 33'(4 * NCHK);

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [NCHK-1:0] hit_q, hit_d, hit_nxt, sel;
  logic            to_q, to_d;
  logic            done_q, fail_q;
  logic [31:0]     ea_q, ea_d, ed_q, ed_d;
  logic            in_win, bad;
  logic [29:0]     word_idx;
  logic [31:0]     exp_word;

  assign in_win   = ({1'b0, dataadr} >= {1'b0, ADDR0}) && ({1'b0, dataadr} < WinEnd);
  assign word_idx = 30'((dataadr - ADDR0) >> 2);

  // Decode the word index into a one-hot select and look up its expected value.
  always_comb begin
    sel      = '0;
    exp_word = '0;
    for (int unsigned i = 0; i < NCHK; i++) begin
      if (word_idx == 30'(i)) begin
        sel[i]   = 1'b1;
        exp_word = EXP[32*i +: 32];
      end
    end
  end

  // Next-state: classify the store, then resolve mismatch > pass > timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    to_d    = to_q;
    ea_d    = ea_q;
    ed_d    = ed_q;
    hit_nxt = hit_q;
    bad     = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        cnt_d = cnt_q + 32'd1;
        if (memwrite && in_win) begin
          if (dataadr[1:0] != 2'b00) begin
            bad = 1'b1;
          end else if (writedata == exp_word) begin
            hit_nxt = hit_q | sel;
          end else begin
            bad = 1'b1;
          end
        end
        hit_d = hit_nxt;
        if (bad) begin
          state_d = StFail;
          ea_d    = dataadr;
          ed_d    = writedata;
        end else if (&hit_nxt) begin
          state_d = StPass;
        end else if (cnt_q == TIMEOUT_CYC - 1) begin
          state_d = StFail;
          to_d    = 1'b1;
          ea_d    = '0;
          ed_d    = '0;
        end
      end
      default: ;  // PASS/FAIL are terminal: everything stays frozen
    endcase
  end

  // State and status registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hit_q   <= '0;
      to_q    <= 1'b0;
      ea_q    <= '0;
      ed_q    <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      to_q    <= to_d;
      ea_q    <= ea_d;
      ed_q    <= ed_d;
      done_q  <= (state_d == StPass) || (state_d == StFail);
      fail_q  <= (state_d == StFail);
    end
  end

  assign state    = state_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign timeout  = to_q;
  assign hit_mask = hit_q;
  assign err_addr = ea_q;
  assign err_data = ed_q;

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench for store_checker: scenario tasks push expected status
// words to a queue as each store is driven and pop/compare after the edge.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;

  logic [1:0]  state, t_state;
  logic        done, fail, timeout, t_done, t_fail, t_timeout;
  logic [3:0]  hit_mask, t_hit_mask;
  logic [31:0] err_addr, err_data, t_err_addr, t_err_data;

  store_checker dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .state(state), .done(done), .fail(fail),
    .timeout(timeout), .hit_mask(hit_mask), .err_addr(err_addr), .err_data(err_data)
  );

  // Short-timeout instance; only checked by the timeout scenarios.
  store_checker #(.TIMEOUT_CYC(20)) dut_t (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .state(t_state), .done(t_done), .fail(t_fail),
    .timeout(t_timeout), .hit_mask(t_hit_mask), .err_addr(t_err_addr),
    .err_data(t_err_data)
  );

  always #5 clk = ~clk;

  typedef logic [72:0] stat_t;
  localparam logic [1:0] SIdle = 2'd0, SRun = 2'd1, SPass = 2'd2, SFail = 2'd3;

  stat_t got, got_t;
  assign got   = {state, done, fail, timeout, hit_mask, err_addr, err_data};
  assign got_t = {t_state, t_done, t_fail, t_timeout, t_hit_mask, t_err_addr, t_err_data};

  stat_t exp_q[$];
  int    n_run = 0;
  int    n_fail = 0;

  function automatic stat_t st(input logic [1:0] s, input logic [3:0] h, input logic to,
                               input logic [31:0] ea, input logic [31:0] ed);
    logic dn, fl;
    dn = (s == SPass) || (s == SFail);
    fl = (s == SFail);
    return {s, dn, fl, to, h, ea, ed};
  endfunction

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  // Reset for one edge, release, then take the IDLE->RUN edge.
  task automatic restart;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    stat_t e;
    #1 reset = 1'b0;
    #1;
    n_run++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got=%h want=%h", got, stat_t'(0));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    // Store on the IDLE->RUN edge must be ignored.
    exp_q.push_back(st(SRun, 4'h0, 1'b0, 32'd0, 32'd0));
    drive(1'b1, 32'd200, 32'h1);
    e = exp_q.pop_front();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL idle_to_run: got=%h want=%h", got, e);
    end
  endtask

  task automatic test_in_order;
    logic [31:0] a[4] = '{32'd200, 32'd204, 32'd208, 32'd212};
    logic [31:0] d[4] = '{32'h1, 32'hffffffff, 32'h64, 32'hC8};
    logic [3:0]  h[4] = '{4'h1, 4'h3, 4'h7, 4'hf};
    stat_t e;
    restart();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(st((i == 3) ? SPass : SRun, h[i], 1'b0, 32'd0, 32'd0));
      drive(1'b1, a[i], d[i]);
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL in_order[%0d]: got=%h want=%h", i, got, e);
      end
    end
    // PASS is sticky: idle cycle and a bad store change nothing.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(st(SPass, 4'hf, 1'b0, 32'd0, 32'd0));
      drive(i == 1, 32'd208, 32'h63);
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pass_sticky[%0d]: got=%h want=%h", i, got, e);
      end
    end
  endtask

  task automatic test_reverse_interleaved;
    logic [31:0] a[9] = '{32'd80, 32'd212, 32'd84, 32'd216, 32'd208, 32'd196,
                          32'd204, 32'd84, 32'd200};
    logic [31:0] d[9] = '{32'h5, 32'hC8, 32'h0, 32'hdead, 32'h64, 32'h1,
                          32'hffffffff, 32'h7, 32'h1};
    logic [3:0]  h[9] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'hc, 4'hc, 4'he, 4'he, 4'hf};
    stat_t e;
    restart();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(st((i == 8) ? SPass : SRun, h[i], 1'b0, 32'd0, 32'd0));
      drive(1'b1, a[i], d[i]);
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reverse[%0d]: got=%h want=%h", i, got, e);
      end
    end
  endtask

  task automatic test_mismatch;
    logic        mw[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] a[6]  = '{32'd200, 32'd208, 32'd212, 32'd0, 32'd204, 32'd204};
    logic [31:0] d[6]  = '{32'h1, 32'h63, 32'hC8, 32'h0, 32'hffffffff, 32'h0};
    stat_t       x[6];
    stat_t       e;
    x[0] = st(SRun, 4'h1, 1'b0, 32'd0, 32'd0);
    x[1] = st(SFail, 4'h1, 1'b0, 32'd208, 32'h63);
    x[2] = x[1];
    x[3] = x[1];
    // Second run: wrong re-store to an already-hit word still fails.
    x[4] = st(SRun, 4'h2, 1'b0, 32'd0, 32'd0);
    x[5] = st(SFail, 4'h2, 1'b0, 32'd204, 32'h0);
    restart();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) restart();
      exp_q.push_back(x[i]);
      drive(mw[i], a[i], d[i]);
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL mismatch[%0d]: got=%h want=%h", i, got, e);
      end
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] a[4] = '{32'd200, 32'd200, 32'd202, 32'd215};
    logic [31:0] d[4] = '{32'h1, 32'h1, 32'h1, 32'hC8};
    stat_t       x[4];
    stat_t       e;
    x[0] = st(SRun, 4'h1, 1'b0, 32'd0, 32'd0);
    x[1] = x[0];
    x[2] = st(SFail, 4'h1, 1'b0, 32'd202, 32'h1);
    // Last byte of the window, otherwise-correct data: still misaligned.
    x[3] = st(SFail, 4'h0, 1'b0, 32'd215, 32'hC8);
    restart();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) restart();
      exp_q.push_back(x[i]);
      drive(1'b1, a[i], d[i]);
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL misaligned[%0d]: got=%h want=%h", i, got, e);
      end
    end
  endtask

  // Runs 20 RUN edges on the TIMEOUT_CYC=20 instance; edge 20 carries the
  // given store and must produce 'fin', which then stays put.
  task automatic run_timeout(input string name, input bit with3, input logic mw20,
                             input logic [31:0] a20, input logic [31:0] d20,
                             input stat_t fin);
    stat_t      e;
    logic [3:0] h;
    restart();
    h = 4'h0;
    for (int ed = 1; ed <= 21; ed++) begin
      if (ed == 1) h = 4'h1;
      else if (ed == 2) h = 4'h3;
      else if (ed == 3 && with3) h = 4'h7;
      exp_q.push_back((ed >= 20) ? fin : st(SRun, h, 1'b0, 32'd0, 32'd0));
      if (ed == 1) drive(1'b1, 32'd200, 32'h1);
      else if (ed == 2) drive(1'b1, 32'd204, 32'hffffffff);
      else if (ed == 3 && with3) drive(1'b1, 32'd208, 32'h64);
      else if (ed == 20) drive(mw20, a20, d20);
      else drive(1'b0, 32'd0, 32'd0);
      e = exp_q.pop_front();
      n_run++;
      if (got_t !== e) begin
        n_fail++;
        $display("FAIL %s edge %0d: got=%h want=%h", name, ed, got_t, e);
      end
    end
  endtask

  task automatic test_timeout;
    run_timeout("timeout", 1'b0, 1'b0, 32'd0, 32'd0, st(SFail, 4'h3, 1'b1, 32'd0, 32'd0));
    run_timeout("pass_on_timeout_edge", 1'b1, 1'b1, 32'd212, 32'hC8,
                st(SPass, 4'hf, 1'b0, 32'd0, 32'd0));
    run_timeout("mismatch_on_timeout_edge", 1'b1, 1'b1, 32'd212, 32'h0,
                st(SFail, 4'h7, 1'b0, 32'd212, 32'h0));
  endtask

  task automatic test_async_reset;
    stat_t e;
    restart();
    exp_q.push_back(st(SRun, 4'h1, 1'b0, 32'd0, 32'd0));
    drive(1'b1, 32'd200, 32'h1);
    exp_q.push_back(st(SRun, 4'h3, 1'b0, 32'd0, 32'd0));
    drive(1'b1, 32'd204, 32'hffffffff);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_run++;
      if (i == 1 && got !== e) begin
        n_fail++;
        $display("FAIL pre_reset: got=%h want=%h", got, e);
      end
    end
    // Drop reset between edges: outputs must clear without a clock.
    #2 reset = 1'b0;
    #1;
    n_run++;
    if (got !== '0 || got_t !== '0) begin
      n_fail++;
      $display("FAIL async_clear: got=%h got_t=%h want=0", got, got_t);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL held_in_reset: got=%h want=0", got);
    end
    reset = 1'b1;
    exp_q.push_back(st(SRun, 4'h0, 1'b0, 32'd0, 32'd0));
    drive(1'b0, 32'd0, 32'd0);
    e = exp_q.pop_front();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rerun: got=%h want=%h", got, e);
    end
    exp_q.push_back(st(SRun, 4'h2, 1'b0, 32'd0, 32'd0));
    drive(1'b1, 32'd204, 32'hffffffff);
    e = exp_q.pop_front();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL restart_empty: got=%h want=%h", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reverse_interleaved();
    test_mismatch();
    test_misaligned();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=still running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
